// File: rtl/cpu_core_pkg.sv
// Shared definitions for the multi-cycle CPU core: opcodes, FSM states and
// instruction field positions.
package cpu_core_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_SHL  = 4'h7;
   localparam logic [3:0] OP_OUT  = 4'h8;
   localparam logic [3:0] OP_JMP  = 4'h9;
   localparam logic [3:0] OP_JZ   = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hB;

   // Instruction word layout: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm8
   localparam int OPC_LSB = 12;
   localparam int RD_LSB  = 10;
   localparam int RS_LSB  = 8;
   localparam int IMM_LSB = 0;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      EXEC,
      HALT
   } state_t;

   function automatic logic is_alu_op(input logic [3:0] opcode);
      return (opcode >= OP_ADD) && (opcode <= OP_SHL);
   endfunction

endpackage

// File: rtl/cpu_alu_param.sv
// Combinational ALU for opcodes 2..7; op is the low three opcode bits and
// zero flags a result of 0.
module cpu_alu_param #(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [2:0]        op,
   output logic [DATA_W-1:0] result,
   output logic              zero
);

   always_comb begin
      result = '0;
      case (op)
         3'd2:    result = a + b;
         3'd3:    result = a - b;
         3'd4:    result = a & b;
         3'd5:    result = a | b;
         3'd6:    result = a ^ b;
         3'd7:    result = {a[DATA_W-2:0], 1'b0};
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/cpu_core_mc.sv
// Multi-cycle CPU core: FETCH/LOAD/EXEC sequencing over a read-synchronous
// instruction memory, 4-entry register file, zero flag and handshaked OUT port.
module cpu_core_mc
   import cpu_core_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [15:0]       imem_rdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              halted
);

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_next;
   logic [15:0]       ir;
   logic [DATA_W-1:0] regs [4];
   logic              z;

   logic [3:0]        opcode;
   logic [1:0]        rd;
   logic [1:0]        rs;
   logic [7:0]        imm;
   logic [3:0]        load_opcode;
   logic [1:0]        load_rd;
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;

   assign opcode      = ir[OPC_LSB +: 4];
   assign rd          = ir[RD_LSB +: 2];
   assign rs          = ir[RS_LSB +: 2];
   assign imm         = ir[IMM_LSB +: 8];
   assign load_opcode = imem_rdata[OPC_LSB +: 4];
   assign load_rd     = imem_rdata[RD_LSB +: 2];

   cpu_alu_param #(
      .DATA_W (DATA_W)
   ) u_alu (
      .a      (regs[rd]),
      .b      (regs[rs]),
      .op     (opcode[2:0]),
      .result (alu_result),
      .zero   (alu_zero)
   );

   always_comb begin
      pc_next = pc + ADDR_W'(1);
      if ((opcode == OP_JMP) || ((opcode == OP_JZ) && z)) begin
         pc_next = imm[ADDR_W-1:0];
      end
   end

   // OUT data is captured on the way into EXEC so out_valid is already high in
   // the first EXEC cycle; an OUT holds EXEC until the consumer takes it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         pc        <= '0;
         ir        <= '0;
         z         <= 1'b0;
         imem_addr <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         halted    <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            regs[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (run) begin
                  state     <= FETCH;
                  imem_addr <= pc;
                  busy      <= 1'b1;
               end
            end
            FETCH: begin
               state <= LOAD;
            end
            LOAD: begin
               ir    <= imem_rdata;
               state <= EXEC;
               if (load_opcode == OP_OUT) begin
                  out_valid <= 1'b1;
                  out_data  <= regs[load_rd];
               end
            end
            EXEC: begin
               if (opcode == OP_LDI) begin
                  regs[rd] <= DATA_W'(imm);
               end else if (is_alu_op(opcode)) begin
                  regs[rd] <= alu_result;
                  z        <= alu_zero;
               end
               if (opcode == OP_HALT) begin
                  state  <= HALT;
                  busy   <= 1'b0;
                  halted <= 1'b1;
               end else if ((opcode != OP_OUT) || out_ready) begin
                  state     <= FETCH;
                  pc        <= pc_next;
                  imem_addr <= pc_next;
                  out_valid <= 1'b0;
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_core_mc.sv
// Self-checking bench: two core instances (16/8 and 8/3 widths) checked against
// an instruction-level reference model plus hand-computed expectations.
module tb_cpu_core_mc;

   logic clk;
   logic reset;

   logic        a_run, a_valid, a_ready, a_busy, a_halted;
   logic [7:0]  a_addr;
   logic [15:0] a_rdata, a_data;

   logic        b_run, b_valid, b_ready, b_busy, b_halted;
   logic [2:0]  b_addr;
   logic [15:0] b_rdata;
   logic [7:0]  b_data;

   logic [15:0] mem_a  [256];
   logic [15:0] mem_b  [8];
   logic [15:0] prog_m [256];
   logic [15:0] pq [$];

   int unsigned iss_out [$];
   int unsigned iss_trace [$];
   bit          iss_halted;
   int unsigned exp_a [$];
   int unsigned exp_b [$];
   int unsigned trace_b [$];

   int n_checks = 0;
   int n_pass   = 0;
   bit mon_a = 0;
   bit mon_b = 0;
   bit prev_stall = 0;
   logic [15:0] prev_data = '0;
   int b_cyc = 0;

   cpu_core_mc #(.DATA_W(16), .ADDR_W(8)) dut_a (
      .clk        (clk),
      .reset      (reset),
      .run        (a_run),
      .imem_addr  (a_addr),
      .imem_rdata (a_rdata),
      .out_data   (a_data),
      .out_valid  (a_valid),
      .out_ready  (a_ready),
      .busy       (a_busy),
      .halted     (a_halted)
   );

   cpu_core_mc #(.DATA_W(8), .ADDR_W(3)) dut_b (
      .clk        (clk),
      .reset      (reset),
      .run        (b_run),
      .imem_addr  (b_addr),
      .imem_rdata (b_rdata),
      .out_data   (b_data),
      .out_valid  (b_valid),
      .out_ready  (b_ready),
      .busy       (b_busy),
      .halted     (b_halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Read-synchronous instruction memories
   always @(posedge clk) begin
      a_rdata <= mem_a[a_addr];
      b_rdata <= mem_b[b_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Instruction-level reference: executes prog_m to HALT, recording emitted
   // values and the sequence of fetched addresses.
   task automatic iss(input int dw, input int aw);
      int unsigned r [4];
      int unsigned m, pc, nxt, a, b, res, imm;
      int op, rd, rs;
      bit zf;
      logic [15:0] w;
      m = (32'd1 << dw) - 1;
      iss_out.delete();
      iss_trace.delete();
      iss_halted = 0;
      for (int i = 0; i < 4; i++) r[i] = 0;
      zf = 0;
      pc = 0;
      for (int step = 0; step < 4096 && !iss_halted; step++) begin
         w = prog_m[pc];
         iss_trace.push_back(pc);
         op  = int'(w[15:12]);
         rd  = int'(w[11:10]);
         rs  = int'(w[9:8]);
         imm = int'(w[7:0]);
         a   = r[rd];
         b   = r[rs];
         nxt = (pc + 1) % (32'd1 << aw);
         case (op)
            1: r[rd] = imm & m;
            2, 3, 4, 5, 6, 7: begin
               case (op)
                  2: res = a + b;
                  3: res = a - b;
                  4: res = a & b;
                  5: res = a | b;
                  6: res = a ^ b;
                  default: res = a * 2;
               endcase
               res = res & m;
               r[rd] = res;
               zf = (res == 0);
            end
            8: iss_out.push_back(a);
            9: nxt = imm % (32'd1 << aw);
            10: if (zf) nxt = imm % (32'd1 << aw);
            11: iss_halted = 1;
            default: ;
         endcase
         pc = nxt;
      end
   endtask

   // Output checker for the 16-bit core: every accepted word must be the next
   // model output, and a stalled word must hold until taken.
   always @(negedge clk) begin
      if (mon_a) begin
         if (a_valid && a_ready) begin
            if (exp_a.size() == 0) begin
               n_checks++;
               $display("[TB] FAIL out_a_extra: got 0x%0h, expected no output", a_data);
            end else begin
               check("out_a", 32'(a_data), exp_a.pop_front());
            end
         end
         if (prev_stall) begin
            check("hold_valid_a", 32'(a_valid), 32'd1);
            check("hold_data_a", 32'(a_data), 32'(prev_data));
         end
         prev_stall = a_valid && !a_ready;
         prev_data  = a_data;
      end else begin
         prev_stall = 0;
      end
   end

   // Checker for the 8-bit core: with out_ready high each instruction takes
   // exactly three cycles, so the fetch address follows the model trace.
   always @(negedge clk) begin
      if (!mon_b) begin
         b_cyc = 0;
      end else begin
         b_cyc++;
         if (b_busy && ((b_cyc - 1) / 3) < trace_b.size())
            check("b_fetch_addr", 32'(b_addr), trace_b[(b_cyc - 1) / 3]);
         if (b_valid && b_ready) begin
            if (exp_b.size() == 0) begin
               n_checks++;
               $display("[TB] FAIL out_b_extra: got 0x%0h, expected no output", b_data);
            end else begin
               check("out_b", 32'(b_data), exp_b.pop_front());
            end
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      a_run = 1'b0;
      b_run = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic prep_a();
      do_reset();
      for (int i = 0; i < 256; i++) begin
         mem_a[i]  = (i < pq.size()) ? pq[i] : 16'hB000;
         prog_m[i] = mem_a[i];
      end
      iss(16, 8);
      exp_a = iss_out;
   endtask

   task automatic go_a(input int rand_ready, input int budget);
      mon_a   = 1;
      a_ready = 1'b1;
      a_run   = 1'b1;
      tick();
      a_run = 1'b0;
      for (int c = 0; c < budget && !a_halted; c++) begin
         if (rand_ready != 0) a_ready = 1'($urandom_range(0, 1));
         tick();
      end
      check("halt_a", 32'(a_halted), 32'd1);
      check("drain_a", exp_a.size(), 32'd0);
   endtask

   task automatic prep_b();
      do_reset();
      for (int i = 0; i < 256; i++) begin
         if (i < 8) mem_b[i] = pq[i];
         prog_m[i] = (i < 8) ? pq[i] : 16'h0000;
      end
      iss(8, 3);
      exp_b   = iss_out;
      trace_b = iss_trace;
   endtask

   task automatic go_b(input int budget);
      b_ready = 1'b1;
      b_run   = 1'b1;
      tick();
      b_run = 1'b0;
      mon_b = 1;
      for (int c = 0; c < budget && !b_halted; c++) tick();
      mon_b = 0;
      check("halt_b", 32'(b_halted), 32'd1);
      check("drain_b", exp_b.size(), 32'd0);
   endtask

   task automatic applyStimulus();
      int vcount, vcyc, c;
      logic [15:0] vdata;
      int len, tgt;
      logic [3:0] op;

      // Reset state
      pq = '{16'hB000};
      prep_a();
      check("rst_valid", 32'(a_valid), 32'd0);
      check("rst_busy", 32'(a_busy), 32'd0);
      check("rst_halted", 32'(a_halted), 32'd0);
      check("rst_addr", 32'(a_addr), 32'd0);
      check("rst_data", 32'(a_data), 32'd0);

      // Basic program: output 8 exactly 12 cycles after run, then HALT
      pq = '{16'h1005, 16'h1403, 16'h2100, 16'h8000, 16'hB000};
      prep_a();
      check("pin_t1_count", iss_out.size(), 32'd1);
      check("pin_t1_value", iss_out[0], 32'd8);
      mon_a   = 1;
      a_ready = 1'b1;
      a_run   = 1'b1;
      tick();
      a_run  = 1'b0;
      vcount = 0;
      vcyc   = 0;
      vdata  = '0;
      for (int k = 1; k <= 18; k++) begin
         if (k == 1) begin
            check("t1_busy_fetch", 32'(a_busy), 32'd1);
            check("t1_addr_fetch", 32'(a_addr), 32'd0);
         end
         if (a_valid) begin
            vcount++;
            vcyc  = k;
            vdata = a_data;
         end
         if (k == 15) check("t1_halted_15", 32'(a_halted), 32'd0);
         if (k == 16) check("t1_halted_16", 32'(a_halted), 32'd1);
         tick();
      end
      check("t1_valid_cycles", vcount, 32'd1);
      check("t1_valid_at", vcyc, 32'd12);
      check("t1_data", 32'(vdata), 32'd8);
      check("drain_t1", exp_a.size(), 32'd0);

      // Taken JZ skips the OUT at address 4
      pq = '{16'h1001, 16'h3000, 16'hA005, 16'h18FF, 16'h8800, 16'h8000, 16'hB000};
      prep_a();
      check("pin_t2_count", iss_out.size(), 32'd1);
      check("pin_t2_value", iss_out[0], 32'd0);
      go_a(0, 100);

      // Backpressure: out_ready low for 4 cycles of OUT 0x2A
      pq = '{16'h102A, 16'h8000, 16'hB000};
      prep_a();
      mon_a   = 1;
      a_ready = 1'b0;
      a_run   = 1'b1;
      tick();
      a_run = 1'b0;
      c = 0;
      while (c < 20 && !a_valid) begin
         tick();
         c++;
      end
      check("t3_valid_seen", 32'(a_valid), 32'd1);
      check("t3_latency", c, 32'd5);
      for (int k = 0; k < 4; k++) begin
         check("t3_stall_valid", 32'(a_valid), 32'd1);
         check("t3_stall_data", 32'(a_data), 32'h2A);
         check("t3_stall_busy", 32'(a_busy), 32'd1);
         check("t3_stall_addr", 32'(a_addr), 32'd1);
         if (k < 3) tick();
      end
      tick();
      a_ready = 1'b1;
      check("t3_accept_valid", 32'(a_valid), 32'd1);
      check("t3_accept_data", 32'(a_data), 32'h2A);
      check("t3_accept_addr", 32'(a_addr), 32'd1);
      tick();
      check("t3_after_valid", 32'(a_valid), 32'd0);
      check("t3_after_addr", 32'(a_addr), 32'd2);
      for (int k = 0; k < 20 && !a_halted; k++) tick();
      check("t3_halt", 32'(a_halted), 32'd1);
      check("drain_t3", exp_a.size(), 32'd0);

      // Reset during an OUT stall, then during LOAD, then a clean restart
      pq = '{16'h1433, 16'h8400, 16'hB000};
      prep_a();
      mon_a   = 0;
      a_ready = 1'b0;
      a_run   = 1'b1;
      tick();
      a_run = 1'b0;
      for (int k = 0; k < 20 && !a_valid; k++) tick();
      check("t6_valid_seen", 32'(a_valid), 32'd1);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_stall_valid", 32'(a_valid), 32'd0);
      check("t6_stall_busy", 32'(a_busy), 32'd0);
      check("t6_stall_addr", 32'(a_addr), 32'd0);
      pq = '{16'h8400, 16'hB000};
      for (int i = 0; i < 256; i++) begin
         mem_a[i]  = (i < pq.size()) ? pq[i] : 16'hB000;
         prog_m[i] = mem_a[i];
      end
      a_run = 1'b1;
      tick();
      a_run = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_load_valid", 32'(a_valid), 32'd0);
      check("t6_load_busy", 32'(a_busy), 32'd0);
      check("t6_load_addr", 32'(a_addr), 32'd0);
      iss(16, 8);
      exp_a = iss_out;
      check("pin_t6_value", iss_out[0], 32'd0);
      go_a(0, 50);

      // 8-bit datapath: 0xFF + 1 wraps to 0 and takes JZ
      pq = '{16'h10FF, 16'h1401, 16'h2100, 16'hA006, 16'h8400, 16'hB000, 16'h8000, 16'hB000};
      prep_b();
      check("pin_b1_count", iss_out.size(), 32'd1);
      check("pin_b1_value", iss_out[0], 32'd0);
      go_b(100);

      // SHL of 0x80 sets Z; JMP 7 then NOP at 7 wraps the fetch to 0
      pq = '{16'hA005, 16'h1880, 16'h7800, 16'h8800, 16'h9007, 16'h8800, 16'hB000, 16'h0000};
      prep_b();
      check("pin_b2_steps", iss_trace.size(), 32'd9);
      check("pin_b2_wrap", iss_trace[6], 32'd0);
      check("pin_b2_outs", iss_out.size(), 32'd2);
      go_b(100);

      // Random forward-branching programs with random backpressure
      for (int it = 0; it < 8; it++) begin
         len = int'($urandom_range(6, 24));
         pq.delete();
         for (int i = 0; i < len - 1; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'hB) op = 4'h8;
            if (op == 4'h9 || op == 4'hA) begin
               tgt = int'($urandom_range(i + 1, len - 1));
               pq.push_back({op, 4'($urandom_range(0, 15)), 8'(tgt)});
            end else begin
               pq.push_back({op, 12'($urandom_range(0, 4095))});
            end
         end
         pq.push_back(16'hB000);
         prep_a();
         go_a(1, 2000);
      end
   endtask

   task automatic checkOutput();
      $display("%0d/%0d checks passed", n_pass, n_checks);
   endtask

   initial begin
      reset   = 1'b1;
      a_run   = 1'b0;
      b_run   = 1'b0;
      a_ready = 1'b1;
      b_ready = 1'b1;
      applyStimulus();
      checkOutput();
      $finish;
   end

endmodule

// File: doc/cpu_core_mc.md
# cpu_core_mc

Parametrised multi-cycle CPU core: successor to the fixed 16-bit single-address CPU, with a program counter, a 4-entry register file, a zero flag, branches and a handshaked output port. It fetches 16-bit instructions from an external synchronous instruction memory and executes them through a FETCH/LOAD/EXEC state machine. It sits at the top of the CPU test designs, with instruction memory instantiated alongside it.

## Interface
Parameters:
- DATA_W, 16, datapath and register width; legal range 8..32.
- ADDR_W, 8, PC and instruction-address width; legal range 1..8.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  leave IDLE and begin execution at PC 0; sampled only in IDLE.
- imem_addr  out  ADDR_W  instruction address.
- imem_rdata  in  16  instruction word; valid one cycle after imem_addr.
- out_data  out  DATA_W  value emitted by OUT.
- out_valid  out  1  out_data valid; held until accepted.
- out_ready  in  1  consumer accepts out_data when high together with out_valid.
- busy  out  1  high in FETCH, LOAD and EXEC.
- halted  out  1  high in HALT.

## Operation
Instruction word: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm8. Opcodes and their effects:
- 0 NOP: no effect.
- 1 LDI: rd = zero-extended imm8.
- 2 ADD: rd = rd + rs.
- 3 SUB: rd = rd - rs.
- 4 AND: rd = rd & rs.
- 5 OR: rd = rd | rs.
- 6 XOR: rd = rd ^ rs.
- 7 SHL: rd = rd << 1, with the bit shifted out dropped.
- 8 OUT: out_data = rd.
- 9 JMP: pc = imm8[ADDR_W-1:0].
- A JZ: jump as JMP if Z = 1.
- B HALT: enter HALT.
- C..F: execute as NOP.

Arithmetic rules:
- All arithmetic is modulo 2^DATA_W.
- Z is updated only by opcodes 2..7: Z = 1 when the written result is 0.
- LDI and OUT leave Z unchanged.

Program counter:
- Non-branch instructions set pc = pc + 1 modulo 2^ADDR_W. The address 2^ADDR_W-1 wraps to 0.
- A JZ with Z = 0 falls through to pc + 1.

State machine states: IDLE, FETCH, LOAD, EXEC, HALT.
- IDLE -> FETCH when run = 1.
- FETCH: drive imem_addr = pc; go to LOAD.
- LOAD: capture imem_rdata into the instruction register; go to EXEC.
- EXEC: perform the operation; go to FETCH, or to HALT for opcode B.
- OUT in EXEC: out_valid is asserted and the FSM stays in EXEC until out_ready = 1. The PC update and the move to FETCH happen in the cycle where out_valid & out_ready.
- HALT is left only by reset. run is ignored outside IDLE.

Reset (any state, including mid-instruction or mid-OUT stall):
- Registers and the instruction register cleared to 0; pc = 0, Z = 0, state = IDLE.
- imem_addr = 0, out_data = 0, out_valid = 0, busy = 0, halted = 0.
- A pending OUT is dropped.

## Timing
- Instruction latency: 3 cycles without stalls, plus one cycle per cycle of out_ready low during OUT.
- run sampled high in IDLE at cycle t: FETCH at t+1, LOAD at t+2, EXEC at t+3.
- Register-file and flag writes take effect at the end of EXEC. The next instruction's EXEC sees them.
- out_valid rises in the first EXEC cycle of an OUT. It falls the cycle after the handshake. out_data is stable while out_valid is high.
- out_ready high before out_valid gives a single-cycle EXEC.
- imem_addr is registered and changes only on entry to FETCH. The memory is read-synchronous.
- A source register equal to the destination register reads the old value.

## Structure
- Shared package cpu_core_pkg holds:
  - opcode localparams (OP_NOP..OP_HALT);
  - the state enum (IDLE/FETCH/LOAD/EXEC/HALT);
  - field-position constants for rd, rs and imm8.
- One sub-module, cpu_alu_param: combinational, parameterised by DATA_W. Inputs a, b and a 3-bit op (opcodes 2..7); outputs result and zero.
- The register file, pc and FSM stay in cpu_core_mc.

## Test plan
1. Reset, then run pulsed, with program LDI r0,5; LDI r1,3; ADD r0,r1; OUT r0; HALT and out_ready tied high. Required: out_data = 8 with out_valid high for exactly 1 cycle, 12 cycles after run is sampled, then halted = 1.
2. Program LDI r0,1; SUB r0,r0; JZ 5; LDI r2,0xFF; OUT r2 (addr 4); OUT r0 (addr 5); HALT. Required: the only output is 0, from address 5; the OUT at address 4 is never emitted.
3. Backpressure: out_ready held low 4 cycles during OUT r0 = 0x2A. Required: out_valid high and out_data = 0x2A for 5 cycles; busy = 1; pc does not advance until the handshake.
4. DATA_W = 8: LDI r0,0xFF; LDI r1,1; ADD r0,r1; JZ 6. Required: r0 = 0x00, Z = 1, branch taken. Also, with Z = 0, SHL of 0x80 produces 0x00 and sets Z = 1.
5. ADDR_W = 3 with JMP 7 and NOP at address 7. Required: the fetch after address 7 has imem_addr = 0 (wrap-around).
6. Reset asserted during an OUT stall and during LOAD. Required: out_valid = 0, busy = 0 and imem_addr = 0 the next cycle; run then restarts from pc 0 with cleared registers.
